// File: rtl/msk_shares_recombine.sv
// msk_shares_recombine
//
// Sequential unmasking stage. Takes a D-share Boolean sharing of an NBITS
// vector, folds it into an accumulator one share per clock, and presents the
// unmasked value and an all-zero flag on a valid/ready output.
//
// Only share 0 goes straight from the input port into the accumulator. Every
// other share is captured in share_reg first and then XORed in, one share per
// cycle. No combinational path ever XORs two shares of the same sharing
// together. The output port is forced to zero whenever the result is not
// final, so partial sums are never visible outside the block.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     in_sharing holds a valid sharing
//   in_ready     block is idle and can accept a sharing
//   in_sharing   D*NBITS bits; share i is at [i*NBITS +: NBITS]
//   out_valid    out_data / out_is_zero hold the final result
//   out_ready    downstream accepts the result
//   out_data     XOR of all shares; zero unless out_valid
//   out_is_zero  result is all-zero; low unless out_valid

module msk_shares_recombine #(
    parameter int D     = 2,
    parameter int NBITS = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [D*NBITS-1:0]   in_sharing,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NBITS-1:0]     out_data,
    output logic                 out_is_zero
);

    localparam int CNT_W = (D > 2) ? $clog2(D) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(D - 1);

    logic [1:0]           state_q,     state_d;
    logic [D*NBITS-1:0]   share_reg_q, share_reg_d;
    logic [NBITS-1:0]     acc_q,       acc_d;
    logic [CNT_W-1:0]     cnt_q,       cnt_d;

    logic [NBITS-1:0]     share_sel;

    // The only share that ever meets acc: the stored one indexed by cnt.
    assign share_sel = share_reg_q[int'(cnt_q)*NBITS +: NBITS];

    // Next-state logic. The last ACC cycle holds cnt at D-1 rather than
    // incrementing it, so cnt never leaves the range of valid share indices.
    always_comb begin
        state_d     = state_q;
        share_reg_d = share_reg_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    share_reg_d = in_sharing;
                    acc_d       = in_sharing[NBITS-1:0];
                    cnt_d       = CNT_W'(1);
                    state_d     = S_ACC;
                end
            end
            S_ACC: begin
                acc_d = acc_q ^ share_sel;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_OUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_OUT: begin
                // Scrub the stored shares and the result once consumed.
                if (out_ready) begin
                    share_reg_d = '0;
                    acc_d       = '0;
                    cnt_d       = '0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                share_reg_d = '0;
                acc_d       = '0;
                cnt_d       = '0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            share_reg_q <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            share_reg_q <= share_reg_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

    // The output gate keeps partial sums in acc away from the output port.
    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_OUT);
    assign out_data    = out_valid ? acc_q : '0;
    assign out_is_zero = out_valid & ~|acc_q;

endmodule
